// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul operand sequencer: word width,
// sequencer state encoding, index-width helper and FP constants.
package matmul_pkg;

   localparam int WORD_WIDTH = 32;

   localparam logic [WORD_WIDTH-1:0] FP_ONE  = 32'h3F800000;
   localparam logic [WORD_WIDTH-1:0] FP_TWO  = 32'h40000000;
   localparam logic [WORD_WIDTH-1:0] FP_ZERO = 32'h00000000;

   typedef enum logic [2:0] {
      LOAD,
      ISSUE,
      WAIT_ACK,
      WAIT_RESULT,
      DRAIN
   } seq_state_t;

   // Index width with a floor of one bit so N=1 still yields legal vectors.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/matrix_bank.sv
// N x N word register store: one write port, a packed row read, a packed
// column read and a scalar element read, all combinational.
module matrix_bank
   import matmul_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [IW-1:0]           wr_row,
   input  logic [IW-1:0]           wr_col,
   input  logic [WORD_WIDTH-1:0]   wr_data,
   input  logic [IW-1:0]           rd_row,
   input  logic [IW-1:0]           rd_col,
   output logic [N*WORD_WIDTH-1:0] row_data,
   output logic [N*WORD_WIDTH-1:0] col_data,
   output logic [WORD_WIDTH-1:0]   elem
);

   logic [N-1:0][N-1:0][WORD_WIDTH-1:0] mem;

   // Contents are don't-care after reset, so the store carries no reset.
   always_ff @(posedge clk) begin
      if (we) mem[wr_row][wr_col] <= wr_data;
   end

   assign row_data = mem[rd_row];
   assign elem     = mem[rd_row][rd_col];

   for (genvar k = 0; k < N; k++) begin : g_col
      assign col_data[k*WORD_WIDTH +: WORD_WIDTH] = mem[k][rd_col];
   end

endmodule

// File: rtl/matmul_operand_sequencer.sv
// Loads A and B word-serially, feeds row/column pairs to inner_product and
// streams the collected C out row-major. MATMUL_SEQ_B_COLMAJOR_EN: B loads column-major.
module matmul_operand_sequencer
   import matmul_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WORD_WIDTH-1:0]   in_data,
   input  logic                    in_stb,
   output logic                    in_ack,
   output logic [N*WORD_WIDTH-1:0] row,
   output logic [N*WORD_WIDTH-1:0] column,
   output logic                    row_o_stb,
   output logic                    column_o_stb,
   input  logic                    row_i_ack,
   input  logic                    column_i_ack,
   input  logic [WORD_WIDTH-1:0]   ip_out,
   input  logic                    ip_out_stb,
   output logic                    ip_out_ack,
   output logic [WORD_WIDTH-1:0]   out_data,
   output logic                    out_stb,
   input  logic                    out_ack,
   output logic                    busy,
   output logic                    done
);

   localparam int N2 = N * N;
   localparam int IW = idx_w(N);
   localparam int OW = idx_w(N2);
   localparam int LW = idx_w(2 * N2);

   seq_state_t state, state_d;
   logic [LW-1:0] ld_cnt, ld_d;
   logic [IW-1:0] i, j, i_d, j_d;
   logic [OW-1:0] o, o_d, c_rd;
   logic [IW-1:0] a_wr_row, a_wr_col, b_wr_row, b_wr_col, c_rd_row, c_rd_col;
   logic          a_we, b_we, c_we, c_fwd;
   logic          in_ack_d, row_stb_d, col_stb_d, ip_ack_d, out_stb_d, done_d, busy_d;
   logic [N*WORD_WIDTH-1:0] row_d, column_d, a_row, b_col;
   logic [WORD_WIDTH-1:0]   out_data_d, c_elem, c_word;
   logic [N*WORD_WIDTH-1:0] a_col_unused, b_row_unused, c_row_unused, c_col_unused;
   logic [WORD_WIDTH-1:0]   a_elem_unused, b_elem_unused;
   int            ld_w;

   // Load-stream position within the current matrix.
   always_comb begin
      ld_w     = int'(ld_cnt) % N2;
      a_wr_row = IW'(ld_w / N);
      a_wr_col = IW'(ld_w % N);
`ifdef MATMUL_SEQ_B_COLMAJOR_EN
      b_wr_row = IW'(ld_w % N);
      b_wr_col = IW'(ld_w / N);
`else
      b_wr_row = IW'(ld_w / N);
      b_wr_col = IW'(ld_w % N);
`endif
   end

   // Next C word to present: index 0 on DRAIN entry, o+1 on each advance.
   assign c_rd     = (state == DRAIN) ? o + OW'(1) : '0;
   assign c_rd_row = IW'(int'(c_rd) / N);
   assign c_rd_col = IW'(int'(c_rd) % N);
   assign c_fwd    = (state == WAIT_RESULT) && ip_out_stb && (c_rd_row == i) && (c_rd_col == j);
   assign c_word   = c_fwd ? ip_out : c_elem;

   matrix_bank #(.N(N), .IW(IW)) u_a (
      .clk(clk), .we(a_we), .wr_row(a_wr_row), .wr_col(a_wr_col), .wr_data(in_data),
      .rd_row(i), .rd_col(j), .row_data(a_row), .col_data(a_col_unused), .elem(a_elem_unused)
   );

   matrix_bank #(.N(N), .IW(IW)) u_b (
      .clk(clk), .we(b_we), .wr_row(b_wr_row), .wr_col(b_wr_col), .wr_data(in_data),
      .rd_row(i), .rd_col(j), .row_data(b_row_unused), .col_data(b_col), .elem(b_elem_unused)
   );

   matrix_bank #(.N(N), .IW(IW)) u_c (
      .clk(clk), .we(c_we), .wr_row(i), .wr_col(j), .wr_data(ip_out),
      .rd_row(c_rd_row), .rd_col(c_rd_col), .row_data(c_row_unused), .col_data(c_col_unused),
      .elem(c_elem)
   );

   always_comb begin
      state_d    = state;
      ld_d       = ld_cnt;
      i_d        = i;
      j_d        = j;
      o_d        = o;
      in_ack_d   = in_ack;
      row_d      = row;
      column_d   = column;
      row_stb_d  = row_o_stb;
      col_stb_d  = column_o_stb;
      ip_ack_d   = ip_out_ack;
      out_data_d = out_data;
      out_stb_d  = out_stb;
      done_d     = 1'b0;
      a_we       = 1'b0;
      b_we       = 1'b0;
      c_we       = 1'b0;
      case (state)
         LOAD: begin
            if (in_stb && in_ack) begin
               a_we = (int'(ld_cnt) < N2);
               b_we = (int'(ld_cnt) >= N2);
               if (ld_cnt == LW'(2*N2-1)) begin
                  ld_d     = '0;
                  in_ack_d = 1'b0;
                  i_d      = '0;
                  j_d      = '0;
                  ip_ack_d = 1'b1;
                  state_d  = ISSUE;
               end else begin
                  ld_d = ld_cnt + LW'(1);
               end
            end
         end
         ISSUE: begin
            row_d    = a_row;
            column_d = b_col;
            // Acks left high from the previous operation must clear first.
            if (!(row_i_ack || column_i_ack)) begin
               row_stb_d = 1'b1;
               col_stb_d = 1'b1;
               state_d   = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (row_i_ack && column_i_ack) begin
               row_stb_d = 1'b0;
               col_stb_d = 1'b0;
               state_d   = WAIT_RESULT;
            end
         end
         WAIT_RESULT: begin
            if (ip_out_stb) begin
               c_we = 1'b1;
               if (i == IW'(N-1) && j == IW'(N-1)) begin
                  o_d        = '0;
                  out_stb_d  = 1'b1;
                  out_data_d = c_word;
                  ip_ack_d   = 1'b0;
                  state_d    = DRAIN;
               end else begin
                  if (j == IW'(N-1)) begin
                     j_d = '0;
                     i_d = i + IW'(1);
                  end else begin
                     j_d = j + IW'(1);
                  end
                  state_d = ISSUE;
               end
            end
         end
         DRAIN: begin
            if (out_ack) begin
               if (o == OW'(N2-1)) begin
                  out_stb_d = 1'b0;
                  done_d    = 1'b1;
                  in_ack_d  = 1'b1;
                  state_d   = LOAD;
               end else begin
                  o_d        = o + OW'(1);
                  out_data_d = c_word;
               end
            end
         end
         default: state_d = LOAD;
      endcase
      busy_d = (state_d != LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LOAD;
         ld_cnt       <= '0;
         i            <= '0;
         j            <= '0;
         o            <= '0;
         in_ack       <= 1'b1;
         row          <= '0;
         column       <= '0;
         row_o_stb    <= 1'b0;
         column_o_stb <= 1'b0;
         ip_out_ack   <= 1'b0;
         out_data     <= '0;
         out_stb      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_d;
         ld_cnt       <= ld_d;
         i            <= i_d;
         j            <= j_d;
         o            <= o_d;
         in_ack       <= in_ack_d;
         row          <= row_d;
         column       <= column_d;
         row_o_stb    <= row_stb_d;
         column_o_stb <= col_stb_d;
         ip_out_ack   <= ip_ack_d;
         out_data     <= out_data_d;
         out_stb      <= out_stb_d;
         busy         <= busy_d;
         done         <= done_d;
      end
   end

endmodule

// File: tb/tb_matmul_operand_sequencer.sv
// Bench for matmul_operand_sequencer: behavioural inner_product with optional
// stale acks, real-valued reference product, scoreboard on the C stream.
module tb_matmul_operand_sequencer;
   import matmul_pkg::*;

   localparam int N = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       in_data;
   logic              in_stb;
   logic              in_ack;
   logic [N*32-1:0]   row, column;
   logic              row_o_stb, column_o_stb;
   logic              row_i_ack, column_i_ack;
   logic [31:0]       ip_out;
   logic              ip_out_stb, ip_out_ack;
   logic [31:0]       out_data;
   logic              out_stb, out_ack;
   logic              busy, done;

   matmul_operand_sequencer #(.N(N)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
      .row(row), .column(column), .row_o_stb(row_o_stb), .column_o_stb(column_o_stb),
      .row_i_ack(row_i_ack), .column_i_ack(column_i_ack), .ip_out(ip_out),
      .ip_out_stb(ip_out_stb), .ip_out_ack(ip_out_ack), .out_data(out_data),
      .out_stb(out_stb), .out_ack(out_ack), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   function automatic real f2r(input logic [31:0] b);
      real m, r;
      int  e;
      if (b[30:0] == 31'h0) return 0.0;
      e = int'(b[30:23]) - 127;
      m = 1.0 + real'(b[22:0]) / 8388608.0;
      r = m * (2.0 ** real'(e));
      return b[31] ? -r : r;
   endfunction

   function automatic logic [31:0] r2f(input real v);
      real         a;
      int          e;
      logic [31:0] b;
      b = 32'h0;
      if (v == 0.0) return b;
      a = (v < 0.0) ? -v : v;
      e = 0;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      b[31]    = (v < 0.0);
      b[30:23] = 8'(e + 127);
      b[22:0]  = 23'($rtoi((a - 1.0) * 8388608.0));
      return b;
   endfunction

   function automatic logic [31:0] stim(input int sel, input int w);
      case (sel)
         0:       return (w / N == w % N) ? FP_ONE : FP_ZERO;
         1:       return FP_TWO;
         default: return r2f(real'(w + 1));
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural inner_product: acks on accept, result after a few cycles;
   // in stale mode the acks stay high for two cycles after the result pulse.
   bit          stale_mode = 1'b0;
   int          ms = 0, mcnt = 0, issues = 0, proto_viol = 0;
   logic [N*32-1:0] m_row, m_col;

   function automatic logic [31:0] dot(input logic [N*32-1:0] r, input logic [N*32-1:0] c);
      real s;
      s = 0.0;
      for (int k = 0; k < N; k++) s = s + f2r(r[k*32 +: 32]) * f2r(c[k*32 +: 32]);
      return r2f(s);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         ms <= 0; mcnt <= 0;
         row_i_ack <= 1'b0; column_i_ack <= 1'b0;
         ip_out_stb <= 1'b0; ip_out <= 32'h0;
      end else begin
         if (ms == 2 && row_o_stb) proto_viol <= proto_viol + 1;
         case (ms)
            0: if (row_o_stb && column_o_stb && !row_i_ack && !column_i_ack) begin
                  m_row <= row; m_col <= column;
                  row_i_ack <= 1'b1; column_i_ack <= 1'b1;
                  mcnt <= 0; ms <= 1; issues <= issues + 1;
               end
            1: begin
                  mcnt <= mcnt + 1;
                  if (mcnt == 1 && !stale_mode) begin row_i_ack <= 1'b0; column_i_ack <= 1'b0; end
                  if (mcnt == 3) begin
                     ip_out <= dot(m_row, m_col); ip_out_stb <= 1'b1; mcnt <= 0; ms <= 2;
                  end
               end
            default: begin
                  ip_out_stb <= 1'b0;
                  mcnt <= mcnt + 1;
                  if (mcnt == 1) begin
                     row_i_ack <= 1'b0; column_i_ack <= 1'b0; ms <= 0;
                  end
               end
         endcase
      end
   end

   typedef struct {
      int          a_sel;
      int          b_sel;
      int          stall_at;
      int          stall_len;
      bit          stale;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } vec_t;

   vec_t        tbl[5];
   logic [31:0] sb[$];

   task automatic load_mats(input int a_sel, input int b_sel);
      for (int w = 0; w < 2*N*N; w++) begin
         @(negedge clk);
         in_stb  = 1'b1;
         in_data = (w < N*N) ? stim(a_sel, w) : stim(b_sel, w - N*N);
      end
      @(negedge clk);
      in_stb = 1'b0;
      chk("load_end_busy_inack", {30'h0, busy, in_ack}, 32'h2);
   endtask

   task automatic run_case(input string nm, input vec_t v);
      real         am[N][N], bm[N][N], s;
      logic [31:0] held, got;
      int          base, n, cyc, stall, dpre, w;
      stale_mode = v.stale;
      base = issues;
      for (w = 0; w < N*N; w++) begin
         am[w/N][w%N] = f2r(stim(v.a_sel, w));
`ifdef MATMUL_SEQ_B_COLMAJOR_EN
         bm[w%N][w/N] = f2r(stim(v.b_sel, w));
`else
         bm[w/N][w%N] = f2r(stim(v.b_sel, w));
`endif
      end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            s = 0.0;
            for (int k = 0; k < N; k++) s = s + am[r][k] * bm[k][c];
            sb.push_back(r2f(s));
         end
      load_mats(v.a_sel, v.b_sel);
      n = 0; cyc = 0; stall = 0; dpre = 0; held = 32'h0;
      while (n < N*N && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (done) dpre++;
         out_ack = 1'b1;
         if (out_stb && n == v.stall_at && stall < v.stall_len) begin
            out_ack = 1'b0;
            if (stall == 0) held = out_data;
            else chk({nm, "_stall_hold"}, {out_data[31:1], out_data[0] & out_stb}, held);
            stall++;
         end
         if (out_stb && out_ack) begin
            got = out_data;
            if (sb.size() > 0) chk({nm, "_c_word"}, got, sb.pop_front());
            if (n == 0)       chk({nm, "_first"}, got, v.exp_first);
            if (n == N*N - 1) chk({nm, "_last"}, got, v.exp_last);
            n++;
         end
      end
      if (n < N*N) begin
         errors++; checks++;
         $display("FAIL %s_timeout: got %0d words expected %0d", nm, n, N*N);
         sb.delete();
      end
      @(negedge clk);
      chk({nm, "_done_inack_busy"}, {29'h0, done, in_ack, busy}, 32'h6);
      @(negedge clk);
      chk({nm, "_done_once"}, {31'h0, done}, 32'h0);
      chk({nm, "_done_early"}, dpre, 32'h0);
      chk({nm, "_issues"}, issues - base, N*N);
      chk({nm, "_ack_guard"}, proto_viol, 32'h0);
   endtask

   initial begin
      rst = 1'b1; in_stb = 1'b0; in_data = 32'h0; out_ack = 1'b1;
      tbl[0] = '{0, 1, -1, 0, 1'b0, FP_TWO, FP_TWO};
      tbl[1] = '{0, 1,  7, 5, 1'b0, FP_TWO, FP_TWO};
      tbl[2] = '{0, 1, -1, 0, 1'b1, FP_TWO, FP_TWO};
      tbl[3] = '{0, 2,  3, 2, 1'b0, 32'h3F800000, 32'h41800000};
`ifdef MATMUL_SEQ_B_COLMAJOR_EN
      tbl[4] = '{2, 2, -1, 0, 1'b1, 32'h41F00000, 32'h44538000};
`else
      tbl[4] = '{2, 2, -1, 0, 1'b1, 32'h42B40000, 32'h44160000};
`endif

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", {25'h0, in_ack, busy, row_o_stb, column_o_stb, ip_out_ack, out_stb, done},
          32'h40);
      chk("rst_row", {31'h0, |row}, 32'h0);
      chk("rst_column", {31'h0, |column}, 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      rst = 1'b0;

      for (int t = 0; t < 5; t++) run_case($sformatf("case%0d", t), tbl[t]);

      // Abort during WAIT_RESULT of element (1,2), then reload from scratch.
      begin
         int base, cyc;
         stale_mode = 1'b0;
         base = issues;
         load_mats(0, 1);
         cyc = 0;
         while (issues - base < 7 && cyc < 2000) begin @(negedge clk); cyc++; end
         chk("midrst_reached", issues - base, 32'd7);
         @(negedge clk);
         chk("midrst_pre_busy", {31'h0, busy}, 32'h1);
         rst = 1'b1;
         @(negedge clk);
         chk("midrst_ctrl", {26'h0, in_ack, busy, row_o_stb, column_o_stb, ip_out_ack, out_stb},
             32'h20);
         rst = 1'b0;
      end
      run_case("reload", tbl[3]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/matmul_operand_sequencer.md
Name: matmul_operand_sequencer

Overview:
- Upstream feeder and result collector for the inner_product stage.
- Word-serially loads square matrices A and B (N x N, 32-bit IEEE-754 single precision) from a stream.
- For each (i,j), presents row i of A and column j of B to inner_product over its stb/ack handshake, then captures the scalar result into C[i][j].
- Streams C out row-major, then returns to loading.

Parameters:
- N, 4, matrix dimension; equals inner_product number_of_elements.
- WORD_WIDTH, 32, element width; fixed, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  32  load word: A row-major, then B row-major.
- in_stb  input  1  load word valid.
- in_ack  output  1  sequencer accepts in_data this cycle.
- row  output  32*N  row i of A; element k in bits [32k+31:32k].
- column  output  32*N  column j of B, same packing.
- row_o_stb  output  1  row valid to inner_product.
- column_o_stb  output  1  column valid to inner_product.
- row_i_ack  input  1  inner_product accepted row.
- column_i_ack  input  1  inner_product accepted column.
- ip_out  input  32  inner_product result.
- ip_out_stb  input  1  result valid; may be a one-cycle pulse.
- ip_out_ack  output  1  drives inner_product out_o_ack; must be high for inner_product to start.
- out_data  output  32  C element, row-major.
- out_stb  output  1  out_data valid.
- out_ack  input  1  consumer accepts out_data.
- busy  output  1  high in any state except LOAD.
- done  output  1  one-cycle pulse after the last C word is accepted.

Behaviour:
- Reset:
  - rst high at a clk edge: state=LOAD; all counters 0.
  - in_ack=1; all other outputs 0 (row, column, out_data zeroed).
  - Reset mid-operation aborts immediately; A/B/C contents become don't-care.
- All outputs are registered.
- LOAD:
  - in_ack=1; a word is taken on each cycle with in_stb&in_ack; load counter 0..2N²-1.
  - Words 0..N²-1 go to A[w/N][w%N]; words N²..2N²-1 go to B.
  - After the final word: in_ack<=0, i=j=0, go to ISSUE.
  - A stalled in_stb simply holds state; there is no timeout.
- ISSUE:
  - ip_out_ack=1; row and column driven from storage for the current (i,j).
  - Waits while row_i_ack|column_i_ack is high; this guards against stale acks that inner_product holds for one idle cycle.
  - When both acks are low: row_o_stb=column_o_stb=1, go to WAIT_ACK.
- WAIT_ACK:
  - Holds stb and data until row_i_ack&column_i_ack.
  - Then drops both stbs next cycle and goes to WAIT_RESULT.
- WAIT_RESULT:
  - ip_out_ack=1; acks are ignored.
  - On the first cycle with ip_out_stb=1: C[i][j]<=ip_out; j<=j+1, wrapping at N with i<=i+1.
  - If (i,j)=(N-1,N-1), go to DRAIN with out counter 0; else go to ISSUE.
- DRAIN:
  - ip_out_ack=0; out_stb=1 with out_data=C[o/N][o%N].
  - On out_stb&out_ack, o advances and the new word appears the next cycle.
  - out_data is stable while out_ack is low.
  - After word N²-1 is accepted: out_stb<=0, done<=1 for one cycle, in_ack<=1, state=LOAD.
- Throughput: one load word per cycle; one output word per cycle when out_ack is held high.
- Simultaneous events:
  - in_stb outside LOAD is ignored.
  - ip_out_stb outside WAIT_RESULT is ignored.

Optional Feature:
- Macro: MATMUL_SEQ_B_COLMAJOR_EN.
- Defined: the B portion of the load stream is column-major, i.e. word N²+w goes to B[w%N][w/N].
- Undefined: B is row-major, as described above.
- A and C ordering are unaffected either way.

Decomposition:
- Package matmul_pkg:
  - WORD_WIDTH=32.
  - Sequencer state encoding: LOAD, ISSUE, WAIT_ACK, WAIT_RESULT, DRAIN.
  - Index-width helper (clog2 of N and N²).
  - FP constants FP_ONE=32'h3F800000, FP_TWO=32'h40000000, FP_ZERO=0.
- Sub-module matrix_bank:
  - N x N register store with a write port (row, col, data).
  - Packed row-read and column-read outputs.
  - Instantiated three times, for A, B and C; C uses only scalar read.

Test Plan:
- Reset: hold rst 2 cycles → in_ack=1, busy=0, all stb=0, done=0, row/column/out_data=0.
- Load A=identity (FP_ONE diagonal) and B all FP_TWO, with real inner_product (N=4) → 16 out words, all 32'h40000000; done pulses once; in_ack=1 the next cycle.
- Same load with out_ack low 5 cycles at word 7 → out_data/out_stb unchanged during the stall; all 16 words still correct, none duplicated.
- Behavioural IP model keeps both acks high for 2 cycles after its result pulse → no row_o_stb until both acks are low; exactly N²=16 issues.
- Assert rst during WAIT_RESULT of (1,2) → next cycle state LOAD, stbs 0, ip_out_ack 0; a full reload then yields correct C.
- With MATMUL_SEQ_B_COLMAJOR_EN, A=identity, B stream 1.0..16.0 → out_data sequence is the transpose (1,5,9,13,2,...).
